// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the memory-mapped UART: register word indices,
// STATUS bit positions, FSM state types and the sticky-flag update helper.
package uart_mmio_pkg;

  localparam int REG_TXDATA  = 0;
  localparam int REG_RXDATA  = 1;
  localparam int REG_STATUS  = 2;
  localparam int REG_DIVISOR = 3;

  localparam int ST_RX_VALID  = 0;
  localparam int ST_TX_FULL   = 1;
  localparam int ST_TX_BUSY   = 2;
  localparam int ST_RX_OVERRUN = 3;
  localparam int ST_RX_FRAME  = 4;
  localparam int ST_TX_DROP   = 5;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Write-1-to-clear flag where a same-cycle set beats the clear.
  function automatic logic sticky_next(input logic cur, input logic set, input logic clr);
    return set | (cur & ~clr);
  endfunction

endpackage

// File: rtl/uart_rx_deser.sv
// 8N1 receive deserialiser: input synchroniser, start-bit qualification,
// mid-bit sampling and single-cycle byte/frame-error pulses.
module uart_rx_deser
  import uart_mmio_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx,
  input  logic [15:0] divisor,
  output logic [7:0]  data,
  output logic        done,
  output logic        frame_err
);

  logic        sync1;
  logic        line;
  logic        line_prev;
  logic        fall;
  rx_state_t   state;
  logic [15:0] cnt;
  logic [15:0] div;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic [15:0] half;
  logic        bit_end;

  assign fall    = line_prev & ~line;
  assign half    = {1'b0, div[15:1]};
  assign bit_end = (cnt == div - 16'd1);
  assign data    = shift;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1     <= 1'b1;
      line      <= 1'b1;
      line_prev <= 1'b1;
    end else begin
      sync1     <= rx;
      line      <= sync1;
      line_prev <= line;
    end
  end

  // Receive FSM; the divisor is captured when a start edge is seen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RX_IDLE;
      cnt       <= 16'd0;
      div       <= 16'd0;
      bit_idx   <= 3'd0;
      shift     <= 8'd0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      done      <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (fall) begin
            state <= RX_START;
            cnt   <= 16'd0;
            div   <= divisor;
          end
        end
        RX_START: begin
          if (cnt == half - 16'd1) begin
            cnt     <= 16'd0;
            bit_idx <= 3'd0;
            state   <= line ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (bit_end) begin
            cnt   <= 16'd0;
            shift <= {line, shift[7:1]};
            if (bit_idx == 3'd7) begin
              state <= RX_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (bit_end) begin
            done      <= line;
            frame_err <= ~line;
            state     <= RX_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state <= RX_IDLE;
          cnt   <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: register file, TX holding register and TX FSM,
// with the receiver in uart_rx_deser. Read data appears one cycle after read_enable.
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter int ADDR_WIDTH   = 2,
  parameter int CLKS_PER_BIT = 234,
  parameter int MIN_DIVISOR  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  write_enable,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           data_in,
  output logic [31:0]           data_out,
  output logic                  uart_tx,
  input  logic                  uart_rx
);

  logic        sel_tx, sel_rx, sel_st, sel_div;
  logic        wr_tx, wr_st, wr_div, pop;
  logic [7:0]  tx_hold;
  logic        tx_full, tx_busy, tx_drop;
  logic        rx_valid, rx_overrun, rx_frame_err;
  logic [7:0]  rx_byte;
  logic [15:0] divisor;
  logic [31:0] status;
  logic [31:0] rd_mux;
  logic [7:0]  rx_data;
  logic        rx_done, rx_ferr;
  tx_state_t   tx_state;
  logic [15:0] tx_cnt, tx_div;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_last, tx_load;
  logic        unused_bits;

  assign sel_tx  = (address == ADDR_WIDTH'(REG_TXDATA));
  assign sel_rx  = (address == ADDR_WIDTH'(REG_RXDATA));
  assign sel_st  = (address == ADDR_WIDTH'(REG_STATUS));
  assign sel_div = (address == ADDR_WIDTH'(REG_DIVISOR));
  assign wr_tx   = write_enable & sel_tx;
  assign wr_st   = write_enable & sel_st;
  assign wr_div  = write_enable & sel_div;
  assign pop     = read_enable & sel_rx;
  assign unused_bits = ^data_in[31:16];

  assign status = {26'd0, tx_drop, rx_frame_err, rx_overrun, tx_busy, tx_full, rx_valid};

  // A holding byte moves to the shifter from IDLE, or straight out of STOP for gap-free frames.
  assign tx_last = (tx_cnt == tx_div - 16'd1);
  assign tx_load = tx_full & ((tx_state == TX_IDLE) | ((tx_state == TX_STOP) & tx_last));

  uart_rx_deser u_rx (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx        (uart_rx),
    .divisor   (divisor),
    .data      (rx_data),
    .done      (rx_done),
    .frame_err (rx_ferr)
  );

  // Read mux over pre-write register values.
  always_comb begin
    rd_mux = 32'd0;
    if (sel_rx) begin
      rd_mux = rx_valid ? {24'd0, rx_byte} : 32'd0;
    end else if (sel_st) begin
      rd_mux = status;
    end else if (sel_div) begin
      rd_mux = {16'd0, divisor};
    end else begin
      rd_mux = 32'd0;
    end
  end

  // Register file, RX buffer and sticky flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out     <= 32'd0;
      tx_hold      <= 8'd0;
      tx_full      <= 1'b0;
      tx_drop      <= 1'b0;
      rx_byte      <= 8'd0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
      divisor      <= 16'(CLKS_PER_BIT);
    end else begin
      if (read_enable) begin
        data_out <= rd_mux;
      end
      if (tx_load) begin
        tx_full <= 1'b0;
      end else if (wr_tx && !tx_full) begin
        tx_full <= 1'b1;
        tx_hold <= data_in[7:0];
      end
      tx_drop      <= sticky_next(tx_drop, wr_tx & tx_full, wr_st & data_in[ST_TX_DROP]);
      rx_frame_err <= sticky_next(rx_frame_err, rx_ferr, wr_st & data_in[ST_RX_FRAME]);
      rx_overrun   <= sticky_next(rx_overrun, rx_done & rx_valid & ~pop,
                                  wr_st & data_in[ST_RX_OVERRUN]);
      if (rx_done) begin
        rx_byte  <= rx_data;
        rx_valid <= 1'b1;
      end else if (pop) begin
        rx_valid <= 1'b0;
      end
      if (wr_div && (data_in[15:0] >= 16'(MIN_DIVISOR))) begin
        divisor <= data_in[15:0];
      end
    end
  end

  // Transmit FSM; the divisor is captured at every frame start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= TX_IDLE;
      uart_tx  <= 1'b1;
      tx_busy  <= 1'b0;
      tx_cnt   <= 16'd0;
      tx_div   <= 16'(CLKS_PER_BIT);
      tx_bit   <= 3'd0;
      tx_shift <= 8'd0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          uart_tx <= ~tx_load;
          tx_busy <= tx_load;
          if (tx_load) begin
            tx_state <= TX_START;
            tx_shift <= tx_hold;
            tx_cnt   <= 16'd0;
            tx_div   <= divisor;
          end
        end
        TX_START: begin
          if (tx_last) begin
            tx_state <= TX_DATA;
            uart_tx  <= tx_shift[0];
            tx_cnt   <= 16'd0;
            tx_bit   <= 3'd0;
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_last) begin
            tx_cnt   <= 16'd0;
            tx_shift <= {1'b0, tx_shift[7:1]};
            if (tx_bit == 3'd7) begin
              tx_state <= TX_STOP;
              uart_tx  <= 1'b1;
            end else begin
              tx_bit  <= tx_bit + 3'd1;
              uart_tx <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        TX_STOP: begin
          if (tx_last) begin
            tx_cnt <= 16'd0;
            if (tx_load) begin
              tx_state <= TX_START;
              uart_tx  <= 1'b0;
              tx_shift <= tx_hold;
              tx_div   <= divisor;
            end else begin
              tx_state <= TX_IDLE;
              tx_busy  <= 1'b0;
            end
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        default: begin
          tx_state <= TX_IDLE;
          uart_tx  <= 1'b1;
          tx_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Randomised self-checking bench for uart_mmio: register accesses, serial
// waveform checks on uart_tx and frames driven onto uart_rx.
module tb_uart_mmio;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        write_enable = 1'b0;
  logic        read_enable = 1'b0;
  logic [1:0]  address = 2'd0;
  logic [31:0] data_in = 32'd0;
  logic [31:0] data_out;
  logic        uart_tx;
  logic        uart_rx = 1'b1;

  int n_checks = 0;
  int n_errors = 0;
  int model_div = 234;
  int j_found = -1;
  int pop_off = 41;
  logic [31:0] rdata;
  logic [7:0]  rx_q[$];

  uart_mmio dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .address      (address),
    .data_in      (data_in),
    .data_out     (data_out),
    .uart_tx      (uart_tx),
    .uart_rx      (uart_rx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    write_enable = 1'b1; address = a; data_in = d;
    @(negedge clk);
    write_enable = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    read_enable = 1'b1; address = a;
    @(negedge clk);
    read_enable = 1'b0;
    d = data_out;
  endtask

  // Drives one 8N1 frame starting now (just after a negedge), then idles the line.
  task automatic drive_frame(input logic [7:0] b, input logic stop_bit, input int d);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = fr[i];
      repeat (d) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (2 * d) @(negedge clk);
  endtask

  // Expected line level: idle, start bit one edge after the write, d clocks per bit.
  task automatic tx_watch(input logic [7:0] b0, input logic [7:0] b1, input int nfr, input int d);
    int k, idx;
    logic [7:0] b;
    logic exp;
    for (int j = 1; j <= nfr * 10 * d + 4; j++) begin
      @(negedge clk);
      k = j - 2;
      exp = 1'b1;
      if (k >= 0 && k < nfr * 10 * d) begin
        idx = k / d;
        b = (idx >= 10) ? b1 : b0;
        idx = idx % 10;
        if (idx == 0) exp = 1'b0;
        else if (idx <= 8) exp = b[idx-1];
        else exp = 1'b1;
      end
      check($sformatf("tx_line[%0d]", j), 32'(uart_tx), 32'(exp));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    logic [7:0] tb;
    int nd;

    repeat (3) @(negedge clk);
    check("reset_tx", 32'(uart_tx), 32'd1);
    check("reset_dout", data_out, 32'd0);
    reset_n = 1'b1;
    rd(2'd2, rdata); check("reset_status", rdata, 32'd0);
    rd(2'd3, rdata); check("reset_div", rdata, 32'd234);
    rd(2'd1, rdata); check("reset_rxdata", rdata, 32'd0);

    wr(2'd3, 32'd4); model_div = 4;
    rd(2'd3, rdata); check("div4", rdata, 32'd4);
    wr(2'd3, 32'd3);
    rd(2'd3, rdata); check("div3_ignored", rdata, 32'd4);
    repeat (3) @(negedge clk);
    check("dout_held", data_out, 32'd4);

    // Write and read in the same cycle: old value returned, write applied.
    @(negedge clk);
    write_enable = 1'b1; read_enable = 1'b1; address = 2'd3; data_in = 32'd5;
    @(negedge clk);
    write_enable = 1'b0; read_enable = 1'b0;
    check("wr_rd_old", data_out, 32'd4);
    rd(2'd3, rdata); check("wr_rd_new", rdata, 32'd5);
    wr(2'd3, 32'd4);

    // Single frame 0x55 with busy tracked through STATUS.
    @(negedge clk);
    write_enable = 1'b1; address = 2'd0; data_in = 32'h55;
    fork
      tx_watch(8'h55, 8'h55, 1, 4);
      begin
        @(negedge clk);
        write_enable = 1'b0; read_enable = 1'b1; address = 2'd2;
        for (int j = 2; j <= 44; j++) begin
          @(negedge clk);
          check($sformatf("tx_busy[%0d]", j), 32'(data_out[2]), 32'((j >= 3 && j <= 42) ? 1 : 0));
        end
        read_enable = 1'b0;
      end
    join

    // Back-to-back frames, third write dropped.
    @(negedge clk);
    write_enable = 1'b1; address = 2'd0; data_in = 32'hA1;
    fork
      tx_watch(8'hA1, 8'h3C, 2, 4);
      begin
        @(negedge clk); write_enable = 1'b0;
        @(negedge clk); write_enable = 1'b1; data_in = 32'h3C;
        @(negedge clk); data_in = 32'hFF;
        @(negedge clk); write_enable = 1'b0; read_enable = 1'b1; address = 2'd2;
        @(negedge clk); read_enable = 1'b0;
        check("status_drop", data_out, 32'h26);
      end
    join
    wr(2'd2, 32'h20);
    rd(2'd2, rdata); check("drop_cleared", rdata, 32'h00);

    // RX 0xC3 while polling STATUS to learn when a byte lands.
    @(negedge clk);
    fork
      drive_frame(8'hC3, 1'b1, 4);
      begin
        read_enable = 1'b1; address = 2'd2;
        for (int j = 1; j <= 60; j++) begin
          @(negedge clk);
          if (j_found < 0 && data_out[0]) j_found = j;
        end
        read_enable = 1'b0;
        check("rx_status_c3", data_out, 32'h01);
      end
    join
    check("rx_seen", 32'(j_found > 2), 32'd1);
    if (j_found > 2) pop_off = j_found - 2;
    rd(2'd1, rdata); check("rx_c3", rdata, 32'hC3);
    rd(2'd2, rdata); check("rx_c3_popped", rdata, 32'h00);
    rd(2'd1, rdata); check("rx_empty", rdata, 32'h00);

    // Overrun then framing error.
    @(negedge clk); drive_frame(8'h11, 1'b1, 4);
    drive_frame(8'h22, 1'b1, 4);
    rd(2'd2, rdata); check("overrun_status", rdata, 32'h09);
    drive_frame(8'h00, 1'b0, 4);
    rd(2'd2, rdata); check("frame_err_status", rdata, 32'h19);
    rd(2'd1, rdata); check("overrun_byte", rdata, 32'h22);
    wr(2'd2, 32'h18);
    rd(2'd2, rdata); check("flags_cleared", rdata, 32'h00);

    // One-clock glitch must not start a frame.
    @(negedge clk); uart_rx = 1'b0;
    @(negedge clk); uart_rx = 1'b1;
    repeat (30) @(negedge clk);
    rd(2'd2, rdata); check("glitch_status", rdata, 32'h00);

    // Pop in the same cycle the next byte completes.
    @(negedge clk); drive_frame(8'h5E, 1'b1, 4);
    @(negedge clk);
    fork
      drive_frame(8'h7B, 1'b1, 4);
      begin
        repeat (pop_off) @(negedge clk);
        read_enable = 1'b1; address = 2'd1;
        @(negedge clk);
        read_enable = 1'b0;
        check("pop_old_byte", data_out, 32'h5E);
      end
    join
    rd(2'd2, rdata); check("pop_coincide_status", rdata, 32'h01);
    rd(2'd1, rdata); check("pop_new_byte", rdata, 32'h7B);

    // Randomised divisor / TX / RX against the model.
    for (int it = 0; it < 6; it++) begin
      nd = $urandom_range(0, 9);
      wr(2'd3, 32'(nd));
      if (nd >= 4) model_div = nd;
      rd(2'd3, rdata); check("rand_div", rdata, 32'(model_div));
      tb = 8'($urandom_range(0, 255));
      @(negedge clk);
      write_enable = 1'b1; address = 2'd0; data_in = {24'd0, tb};
      fork
        tx_watch(tb, tb, 1, model_div);
        begin @(negedge clk); write_enable = 1'b0; end
      join
      rb = 8'($urandom_range(0, 255));
      rx_q.push_back(rb);
      @(negedge clk); drive_frame(rb, 1'b1, model_div);
      rd(2'd2, rdata); check("rand_rx_status", rdata, 32'h01);
      rd(2'd1, rdata); check("rand_rx_byte", rdata, {24'd0, rx_q.pop_front()});
    end

    // Reset in the middle of a TX frame.
    @(negedge clk);
    write_enable = 1'b1; address = 2'd0; data_in = 32'h5A;
    @(negedge clk); write_enable = 1'b0;
    @(negedge clk);
    check("tx_start_low", 32'(uart_tx), 32'd0);
    #2 reset_n = 1'b0;
    #1 check("async_reset_tx", 32'(uart_tx), 32'd1);
    check("async_reset_dout", data_out, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    model_div = 234;
    rd(2'd2, rdata); check("post_reset_status", rdata, 32'h00);
    rd(2'd3, rdata); check("post_reset_div", rdata, 32'(model_div));
    repeat (5) @(negedge clk);
    check("post_reset_tx_idle", 32'(uart_tx), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
